// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Core-side request/response channel of the load/store unit.
//   master : the core (drives the request, observes ready and the response)
//   slave  : the load/store unit
//   Signals:
//     req_valid/req_ready   request handshake, transfer on valid && ready
//     req_we                1 = store, 0 = load
//     req_size              00 byte, 01 half, 10 word, 11 illegal
//     req_unsigned          loads: 1 = zero-extend, 0 = sign-extend
//     req_addr              byte address
//     req_wdata             store data, right-justified
//     resp_valid            single-cycle response pulse
//     resp_rdata            extended load data (0 for stores/misaligned)
//     resp_misaligned       request was misaligned or illegal
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_misaligned;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Sub-word load/store front end between the core memory stage and a
//   word-wide data memory with a registered read port.
//   - Only word-aligned addresses are presented to memory.
//   - Byte/half stores are done as read-modify-write.
//   - Byte/half loads are sign- or zero-extended.
//   - Misaligned or illegal-size requests answer immediately and never
//     touch memory.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     core       load_store_unit_if.slave request/response channel
//     mem_a      word-aligned memory address (0 when idle)
//     mem_wd     memory write data (0 outside the write cycle)
//     mem_we     memory write enable (memory reads while low)
//     mem_rd     memory read data, valid the cycle after the address edge
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  core,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        RMW_RD,
        WR,
        RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state;
    state_t            state_nx;

    // Request captured at the handshake.
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic              mis_q;
    logic [31:0]       wdata_q;

    logic              accept;
    logic              req_mis;

    // Lane handling
    logic [4:0]        lane_shift;
    logic [31:0]       lane_mask;
    logic [31:0]       lane_data;
    logic [31:0]       merged;
    logic [31:0]       rd_shifted;
    logic [31:0]       load_ext;

    assign accept = core.req_valid && (state == IDLE);

    always_comb begin
        req_mis = 1'b0;
        case (core.req_size)
            SZ_BYTE: req_mis = 1'b0;
            SZ_HALF: req_mis = core.req_addr[0];
            SZ_WORD: req_mis = |core.req_addr[1:0];
            default: req_mis = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            mis_q   <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= core.req_addr;
            size_q  <= core.req_size;
            we_q    <= core.req_we;
            uns_q   <= core.req_unsigned;
            mis_q   <= req_mis;
            wdata_q <= core.req_wdata;
        end
    end

    // Lane position: byte k sits at bits [8k+7:8k], half h at [16h+15:16h].
    // mem_rd is the word read for the latched address, so it feeds both the
    // store merge (in WR) and the load extension (in RESP).
    always_comb begin
        lane_shift = '0;
        lane_mask  = '0;
        if (size_q == SZ_BYTE) begin
            lane_shift = {addr_q[1:0], 3'b000};
            lane_mask  = 32'h0000_00FF << lane_shift;
        end else begin
            lane_shift = {addr_q[1], 4'b0000};
            lane_mask  = 32'h0000_FFFF << lane_shift;
        end
        lane_data  = wdata_q << lane_shift;
        merged     = (mem_rd & ~lane_mask) | (lane_data & lane_mask);
        rd_shifted = mem_rd >> lane_shift;
        case (size_q)
            SZ_BYTE: load_ext = {{24{~uns_q & rd_shifted[7]}},  rd_shifted[7:0]};
            SZ_HALF: load_ext = {{16{~uns_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_ext = mem_rd;
        endcase
    end

    // NOTE: every signal written here is given a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nx             = state;
        core.req_ready       = (state == IDLE);
        core.resp_valid      = 1'b0;
        core.resp_rdata      = '0;
        core.resp_misaligned = 1'b0;
        mem_a                = '0;
        mem_wd               = '0;
        mem_we               = 1'b0;

        // The aligned address stays on the bus from the read cycle through
        // RESP so the registered read data remains valid for the load result.
        if (state != IDLE && !mis_q) begin
            mem_a = {addr_q[ADDR_W-1:2], 2'b00};
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_mis) begin
                        state_nx = RESP;
                    end else if (!core.req_we) begin
                        state_nx = LD_RD;
                    end else if (core.req_size == SZ_WORD) begin
                        state_nx = WR;
                    end else begin
                        state_nx = RMW_RD;
                    end
                end
            end
            LD_RD:  state_nx = RESP;
            RMW_RD: state_nx = WR;
            WR: begin
                mem_we   = 1'b1;
                mem_wd   = (size_q == SZ_WORD) ? wdata_q : merged;
                state_nx = RESP;
            end
            RESP: begin
                core.resp_valid      = 1'b1;
                core.resp_misaligned = mis_q;
                if (!we_q && !mis_q) begin
                    core.resp_rdata = load_ext;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Self-checking bench for load_store_unit. A word memory with a registered
//   read port sits on the mem_* side. Expected results come from a byte-array
//   model of memory: stores write individual bytes, loads assemble bytes
//   little-endian and extend arithmetically, and response/write timing is
//   predicted from the request class alone.
module tb_load_store_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd;
    logic              mem_we;
    logic [31:0]       mem_rd;

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .core   (bus),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_we (mem_we),
        .mem_rd (mem_rd)
    );

    // Word memory, 4 KiB, registered read while not writing.
    logic [31:0] tb_mem [0:1023];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_a[11:2]] <= mem_wd;
        else        mem_rd <= tb_mem[mem_a[11:2]];
    end

    // Reference model: flat byte memory.
    logic [7:0] ref_bytes [0:4095];

    typedef struct {
        bit          we;
        bit [1:0]    size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        logic [31:0] w;
        int base;
        w    = '0;
        base = a & ~3;
        for (int i = 0; i < 4; i++) w = w | (32'(ref_bytes[base + i]) << (8 * i));
        return w;
    endfunction

    task automatic drive_garbage(input bit valid);
        bus.req_valid    = valid;
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = 32'($urandom_range(0, 4095));
        bus.req_wdata    = $urandom;
    endtask

    function automatic req_t mk(input bit we, input bit [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    // One transaction. Starts at the next falling edge, which must be an IDLE
    // cycle; the request is accepted at the following rising edge. If hold is
    // set, req_valid stays high with junk after the response so the next call
    // exercises back-to-back acceptance.
    task automatic txn(input req_t r, input bit hold,
                       output logic [31:0] rdata_o, output logic [31:0] wd_o);
        bit          mis;
        int          nbytes;
        int          exp_resp;
        int          exp_we_cyc;
        int          got_resp;
        int          we_cnt;
        int          we_cyc;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [31:0] aligned;
        logic [31:0] got_wa;
        logic [31:0] val;

        mis     = (r.size == 2'd3) || (r.size == 2'd1 && r.addr[0]) ||
                  (r.size == 2'd2 && r.addr[1:0] != 2'b00);
        nbytes  = (r.size == 2'd3) ? 0 : (1 << r.size);
        aligned = r.addr & ~32'h3;
        exp_rd  = '0;
        if (!mis && !r.we) begin
            val = '0;
            for (int i = 0; i < nbytes; i++)
                val = val | (32'(ref_bytes[int'(r.addr) + i]) << (8 * i));
            if (!r.uns && nbytes < 4 && ((val >> (8 * nbytes - 1)) & 32'd1) == 32'd1)
                val = val | (32'hFFFF_FFFF << (8 * nbytes));
            exp_rd = val;
        end
        if (!mis && r.we) begin
            for (int i = 0; i < nbytes; i++)
                ref_bytes[int'(r.addr) + i] = 8'(r.wdata >> (8 * i));
        end
        exp_wd     = ref_word(int'(r.addr));
        exp_resp   = mis ? 1 : ((r.we && r.size != 2'd2) ? 3 : 2);
        exp_we_cyc = (mis || !r.we) ? 0 : ((r.size == 2'd2) ? 1 : 2);

        @(negedge clk);
        check("idle_ready", 32'(bus.req_ready), 32'd1);
        check("idle_mem_a", mem_a, 32'd0);
        check("idle_mem_wd", mem_wd, 32'd0);
        bus.req_valid    = 1'b1;
        bus.req_we       = r.we;
        bus.req_size     = r.size;
        bus.req_unsigned = r.uns;
        bus.req_addr     = r.addr;
        bus.req_wdata    = r.wdata;

        got_resp = 0; we_cnt = 0; we_cyc = 0;
        rdata_o  = '0; wd_o = '0; got_wa = '0;
        for (int c = 1; c <= 8 && got_resp == 0; c++) begin
            @(negedge clk);
            check("busy_ready", 32'(bus.req_ready), 32'd0);
            if (mem_we) begin
                we_cnt++;
                we_cyc = c;
                wd_o   = mem_wd;
                got_wa = mem_a;
            end
            if (bus.resp_valid) begin
                got_resp = c;
                rdata_o  = bus.resp_rdata;
                check("resp_rdata", bus.resp_rdata, exp_rd);
                check("resp_misaligned", 32'(bus.resp_misaligned), 32'(mis));
                if (hold) drive_garbage(1'b1);
                else      bus.req_valid = 1'b0;
            end else begin
                drive_garbage(1'b1);
            end
        end
        if (got_resp == 0) bus.req_valid = 1'b0;

        check("resp_cycle", 32'(got_resp), 32'(exp_resp));
        check("we_count", 32'(we_cnt), (exp_we_cyc != 0) ? 32'd1 : 32'd0);
        check("we_cycle", 32'(we_cyc), 32'(exp_we_cyc));
        if (exp_we_cyc != 0 && we_cnt == 1) begin
            check("mem_wd", wd_o, exp_wd);
            check("mem_a", got_wa, aligned);
        end
    endtask

    logic [31:0] rd;
    logic [31:0] wd;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            tb_mem[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_bytes[4 * i + b] = 8'(tb_mem[i] >> (8 * b));
        end
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        // Reset values
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_mis", 32'(bus.resp_misaligned), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Word store then load
        txn(mk(1, 2'd2, 0, 32'h100, 32'hDEAD_BEEF), 0, rd, wd);
        check("sw_wd", wd, 32'hDEAD_BEEF);
        txn(mk(0, 2'd2, 0, 32'h100, 32'h0), 0, rd, wd);
        check("lw_100", rd, 32'hDEAD_BEEF);

        // Byte and half read-modify-write
        txn(mk(1, 2'd2, 0, 32'h100, 32'h1122_3344), 0, rd, wd);
        txn(mk(1, 2'd0, 0, 32'h102, 32'h0000_00AB), 0, rd, wd);
        check("sb_wd", wd, 32'h11AB_3344);
        txn(mk(1, 2'd1, 0, 32'h100, 32'h0000_BEEF), 0, rd, wd);
        check("sh_wd", wd, 32'h11AB_BEEF);

        // Extension
        txn(mk(1, 2'd2, 0, 32'h200, 32'h8070_F0FF), 0, rd, wd);
        txn(mk(0, 2'd0, 0, 32'h201, 32'h0), 0, rd, wd);
        check("lb_201", rd, 32'hFFFF_FFF0);
        txn(mk(0, 2'd0, 1, 32'h201, 32'h0), 0, rd, wd);
        check("lbu_201", rd, 32'h0000_00F0);
        txn(mk(0, 2'd1, 0, 32'h202, 32'h0), 0, rd, wd);
        check("lh_202", rd, 32'hFFFF_8070);
        txn(mk(0, 2'd1, 1, 32'h202, 32'h0), 0, rd, wd);
        check("lhu_202", rd, 32'h0000_8070);

        // Misaligned and illegal size
        txn(mk(0, 2'd2, 0, 32'h103, 32'h0), 0, rd, wd);
        txn(mk(1, 2'd1, 0, 32'h101, 32'h5555), 0, rd, wd);
        txn(mk(1, 2'd3, 0, 32'h100, 32'h1234_5678), 0, rd, wd);
        check("mis_mem_100", tb_mem[32'h100 >> 2], 32'h11AB_BEEF);

        // Back-to-back with req_valid held high
        txn(mk(1, 2'd2, 0, 32'h300, 32'hCAFE_F00D), 1, rd, wd);
        txn(mk(0, 2'd2, 0, 32'h300, 32'h0), 1, rd, wd);
        check("b2b_lw", rd, 32'hCAFE_F00D);
        txn(mk(1, 2'd0, 0, 32'h301, 32'h0000_0012), 1, rd, wd);
        txn(mk(0, 2'd1, 1, 32'h300, 32'h0), 0, rd, wd);
        check("b2b_lhu", rd, 32'h0000_120D);

        // Reset during RMW_RD of a byte store
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h402;
        bus.req_wdata    = 32'h0000_0077;
        @(negedge clk);
        check("rmw_busy", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_ready", 32'(bus.req_ready), 32'd1);
        check("arst_mem_we", 32'(mem_we), 32'd0);
        check("arst_mem_a", mem_a, 32'd0);
        check("arst_resp", 32'(bus.resp_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("inrst_mem_we", 32'(mem_we), 32'd0);
            check("inrst_resp", 32'(bus.resp_valid), 32'd0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_ready", 32'(bus.req_ready), 32'd1);
            check("post_rst_mem_we", 32'(mem_we), 32'd0);
            check("post_rst_resp", 32'(bus.resp_valid), 32'd0);
        end
        check("rst_mem_unchanged", tb_mem[32'h400 >> 2], ref_word(32'h400));

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            req_t r;
            r.we    = 1'($urandom);
            r.size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r.uns   = 1'($urandom);
            r.addr  = 32'($urandom_range(0, 4095));
            r.wdata = $urandom;
            // Mostly aligned addresses so most requests reach memory.
            if ($urandom_range(0, 3) != 0) begin
                if (r.size == 2'd1) r.addr[0]   = 1'b0;
                if (r.size == 2'd2) r.addr[1:0] = 2'b00;
            end
            txn(r, (n != 299) && ($urandom_range(0, 1) == 1), rd, wd);
        end

        // Final memory image against the byte model
        @(negedge clk);
        for (int i = 0; i < 1024; i++) check("final_mem", tb_mem[i], ref_word(4 * i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sub-word load/store front end between the core's memory-stage request and the word-wide data memory. Accepts byte/half/word loads and stores on a valid/ready handshake, issues only word-aligned accesses to memory, performs read-modify-write for byte and half stores, and sign- or zero-extends load data. Misaligned accesses are flagged and never reach memory.

## Interface
- ADDR_W, 32, byte-address width; mem_a is ADDR_W bits, low 2 bits always 0.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as misaligned).
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  32  extended load data during resp_valid for loads; 0 otherwise.
- resp_misaligned  out  1  valid with resp_valid; request was misaligned or illegal.
- mem_a  out  ADDR_W  word-aligned memory address.
- mem_wd  out  32  memory write data.
- mem_we  out  1  memory write enable; memory reads whenever low.
- mem_rd  in  32  memory read data, registered in memory (valid the cycle after the address edge).

## Operation
- States: IDLE, LD_RD, RMW_RD, WR, RESP.
- Handshake: transfer when req_valid && req_ready at a rising edge; addr, size, we, unsigned, wdata latched.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, size 11. IDLE -> RESP; resp_misaligned=1, resp_rdata=0; no mem_we.
- Load: IDLE -> LD_RD -> RESP. LD_RD drives mem_a = {addr[ADDR_W-1:2],2'b00}, mem_we=0. In RESP mem_a is held, resp_rdata is derived combinationally from mem_rd.
- Word store: IDLE -> WR -> RESP. WR: mem_we=1, mem_wd = wdata.
- Byte/half store: IDLE -> RMW_RD -> WR -> RESP. RMW_RD reads the word. WR: mem_we=1, mem_wd = mem_rd with the selected lane replaced.
- Lanes (little-endian): byte k = addr[1:0] occupies bits [8k+7:8k]. Half h = addr[1] occupies bits [16h+15:16h]. Store merge uses wdata[7:0] or wdata[15:0].
- Extension: byte/half loads replicate the lane MSB (signed) or zero-fill (unsigned). Word loads pass through unchanged.
- RESP lasts exactly one cycle, then -> IDLE. mem_we=1 only in WR.
- mem_a holds the latched aligned address from LD_RD/RMW_RD through RESP. mem_a and mem_wd are 0 in IDLE.
- Reset, at any time: state -> IDLE immediately.
  - Outputs forced to reset values; the in-flight request is dropped with no response.
  - A write not yet clocked in WR never occurs.

## Timing
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_we=0, mem_a=0, mem_wd=0.
- Accept at edge T0 (end of cycle 0). resp_valid in:
  - misaligned: cycle 1.
  - load: cycle 2.
  - word store: cycle 2.
  - byte/half store: cycle 3.
- mem_we high: word store in cycle 1; byte/half store in cycle 2. Exactly one cycle per store, never for loads or misaligned requests.
- req_ready=0 from cycle 1 through the RESP cycle. The next request is accepted no earlier than the first IDLE cycle after RESP.
- req_* ignored while req_ready=0.

## Test plan
- Word store 0xDEADBEEF @0x100, then lw 0x100: mem_we high one cycle (cycle 1), store resp cycle 2; load resp_rdata=0xDEADBEEF in cycle 2 after accept.
- Memory word 0x11223344 @0x100; sb 0xAB @0x102: mem_we only in cycle 2, mem_wd=0x11AB3344, resp cycle 3. Then sh 0xBEEF @0x100 -> word 0x11ABBEEF.
- Word 0x8070F0FF @0x200:
  - lb 0x201 -> 0xFFFFFFF0; lbu 0x201 -> 0x000000F0.
  - lh 0x202 -> 0xFFFF8070; lhu 0x202 -> 0x00008070.
- lw 0x103, sh 0x101, size=11 @0x100: each gives resp_valid in cycle 1 with resp_misaligned=1, resp_rdata=0. mem_we never high; memory unchanged.
- req_valid held high with back-to-back requests: req_ready low cycles 1..RESP. Second request accepted in the first IDLE cycle; no request lost or duplicated.
- rst pulsed during RMW_RD of sb: mem_we never asserts, no resp_valid, memory word unchanged, req_ready=1 after reset release.
